// File: rtl/proc_sequencer_if.sv
// proc_sequencer_if: host/memory-control bundle for proc_sequencer
// Ports: start_i (host start), done_o/busy_o/host_grant_o (status), rd_en_o/rd_addr_o (A/B/OP reads),
// wr_en_o/wr_addr_o (result writes), base_addr_i/len_i (run range, only with SEQ_RANGE_EN).
// Modports: master = host side, slave = sequencer side.
interface proc_sequencer_if #(parameter int ADDR_WIDTH = 10);
  logic start_i, done_o, busy_o, host_grant_o, rd_en_o, wr_en_o;
  logic [ADDR_WIDTH-1:0] rd_addr_o, wr_addr_o;
`ifdef SEQ_RANGE_EN
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0] len_i;
  modport master(output start_i, base_addr_i, len_i, input done_o, busy_o, host_grant_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o);
  modport slave(input start_i, base_addr_i, len_i, output done_o, busy_o, host_grant_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o);
`else
  modport master(output start_i, input done_o, busy_o, host_grant_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o);
  modport slave(input start_i, output done_o, busy_o, host_grant_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o);
`endif
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer: walks operand/opcode memories and issues result writes L=RD_LAT+ALU_LAT cycles later
// Ports: CLK, RST (sync, active-high), bus (proc_sequencer_if.slave).
// Optional macro SEQ_RANGE_EN: run covers len_i elements from base_addr_i; otherwise the full memory.
module proc_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT = 1,
  parameter int ALU_LAT = 1
) (
  input logic CLK,
  input logic RST,
  proc_sequencer_if.slave bus
);
  localparam int L = RD_LAT + ALU_LAT;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] base, base_in, rd_addr;
  logic [ADDR_WIDTH:0] len, len_in, cnt;
  logic [L-1:0] vld;
  logic [ADDR_WIDTH-1:0] addr_p [L];
  logic rd_en;
`ifdef SEQ_RANGE_EN
  assign base_in = bus.base_addr_i;
  assign len_in = bus.len_i > DEPTH ? DEPTH : bus.len_i;
`else
  assign base_in = '0;
  assign len_in = DEPTH;
`endif
  assign rd_en = state == RUN;
  assign rd_addr = base + cnt[ADDR_WIDTH-1:0];
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (bus.start_i ? (len_in == '0 ? DONE : RUN) : IDLE)
             : state == RUN   ? (cnt == len - 1'b1 ? DRAIN : RUN)
             : state == DRAIN ? ((vld << 1) == '0 ? DONE : DRAIN)
             : (bus.start_i ? DONE : IDLE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      len <= '0;
      vld <= '0;
    end else begin
      state <= state_nx;
      vld <= (vld << 1) | L'(rd_en);
      if (state == IDLE && bus.start_i) begin
        base <= base_in;
        len <= len_in;
        cnt <= '0;
      end else if (rd_en) cnt <= cnt + 1'b1;
    end
  end
  // Address pipeline needs no reset: its outputs are qualified by vld.
  always_ff @(posedge CLK) begin
    addr_p[0] <= rd_addr;
    for (int i = 1; i < L; i++) addr_p[i] <= addr_p[i-1];
  end
  assign bus.busy_o = state == RUN || state == DRAIN;
  assign bus.host_grant_o = !(state == RUN || state == DRAIN);
  assign bus.done_o = state == DONE;
  assign bus.rd_en_o = rd_en;
  assign bus.rd_addr_o = rd_en ? rd_addr : '0;
  assign bus.wr_en_o = vld[L-1];
  assign bus.wr_addr_o = vld[L-1] ? addr_p[L-1] : '0;
endmodule
